// File: rtl/snn_csr_apb4.sv
// APB4 register block for one SNN layer: weight / threshold arrays, layer control,
// sticky status with W1C, start strobe, saturating spike counter and interrupt.
module snn_csr_apb4 #(
    parameter int          INPUT_SIZE              = 8,
    parameter int          OUTPUT_SIZE             = 4,
    parameter int          WEIGHT_W                = 16,
    parameter int          THRESH_W                = 16,
    parameter int          CNT_W                   = 16,
    parameter int          READ_WAIT               = 1,
    parameter logic [15:0] WEIGHT_BASE_ADDR        = 16'h0000,
    parameter logic [15:0] SPIKE_THRESH_BASE_ADDR  = 16'h1000,
    parameter logic [15:0] NEURON_THRESH_BASE_ADDR = 16'h2000,
    parameter logic [15:0] CTRL_BASE_ADDR          = 16'h3000
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  psel,
    input  logic                                                  penable,
    input  logic                                                  pwrite,
    input  logic [15:0]                                           paddr,
    input  logic [31:0]                                           pwdata,
    input  logic [3:0]                                            pstrb,
    output logic [31:0]                                           prdata,
    output logic                                                  pready,
    output logic                                                  pslverr,
    output logic [INPUT_SIZE*OUTPUT_SIZE-1:0][WEIGHT_W-1:0]       weight_reg,
    output logic [INPUT_SIZE*OUTPUT_SIZE-1:0][THRESH_W-1:0]       spike_threshold,
    output logic [OUTPUT_SIZE-1:0][THRESH_W-1:0]                  neuron_threshold,
    output logic                                                  layer_en,
    output logic                                                  start_pulse,
    input  logic                                                  layer_busy,
    input  logic                                                  layer_done,
    input  logic                                                  out_spike,
    output logic                                                  irq
);
    localparam int N  = INPUT_SIZE * OUTPUT_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam logic [1:0]       RW      = 2'(READ_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {R_NONE, R_W, R_ST, R_NT, R_CTRL, R_STAT, R_CNT} region_t;
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state;
    region_t           region, region_q;
    logic [IW-1:0]     idx, idx_q;
    logic [OW-1:0]     nidx, nidx_q;
    logic              wr_q, err_q;
    logic [1:0]        rd_cnt;
    logic [15:0]       off_w, off_s, off_n, off_c;
    logic [31:0]       rdata, wm_w, wm_s, wm_n;
    logic              err_c, wr_go, err_set;
    logic              irq_en, done_st, err_st;
    logic [CNT_W-1:0]  spike_cnt;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    assign off_w = paddr - WEIGHT_BASE_ADDR;
    assign off_s = paddr - SPIKE_THRESH_BASE_ADDR;
    assign off_n = paddr - NEURON_THRESH_BASE_ADDR;
    assign off_c = paddr - CTRL_BASE_ADDR;

    always_comb begin
        region = R_NONE;
        if (paddr >= WEIGHT_BASE_ADDR && {16'b0, off_w} < 32'(N * 4))
            region = R_W;
        else if (paddr >= SPIKE_THRESH_BASE_ADDR && {16'b0, off_s} < 32'(N * 4))
            region = R_ST;
        else if (paddr >= NEURON_THRESH_BASE_ADDR && {16'b0, off_n} < 32'(OUTPUT_SIZE * 4))
            region = R_NT;
        else if (paddr >= CTRL_BASE_ADDR && off_c < 16'd12)
            case (off_c[3:2])
                2'd0:    region = R_CTRL;
                2'd1:    region = R_STAT;
                default: region = R_CNT;
            endcase
        idx  = (region == R_W) ? off_w[IW+1:2] : off_s[IW+1:2];
        nidx = off_n[OW+1:2];
        err_c = (region == R_NONE) || (pwrite && region == R_CNT);
    end

    // Read data is taken from the live address during setup and held until the next setup.
    always_comb begin
        rdata = '0;
        case (region)
            R_W:    rdata[WEIGHT_W-1:0] = weight_reg[idx];
            R_ST:   rdata[THRESH_W-1:0] = spike_threshold[idx];
            R_NT:   rdata[THRESH_W-1:0] = neuron_threshold[nidx];
            R_CTRL: rdata[2:0]          = {irq_en, 1'b0, layer_en};
            R_STAT: rdata[2:0]          = {err_st, done_st, layer_busy};
            R_CNT:  rdata[CNT_W-1:0]    = spike_cnt;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            region_q <= R_NONE;
            idx_q    <= '0;
            nidx_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt   <= '0;
            prdata   <= '0;
            pready   <= 1'b1;
            pslverr  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (psel && !penable) begin
                    state    <= ACCESS;
                    region_q <= region;
                    idx_q    <= idx;
                    nidx_q   <= nidx;
                    wr_q     <= pwrite;
                    err_q    <= err_c;
                    rd_cnt   <= RW;
                    prdata   <= (pwrite || err_c) ? 32'd0 : rdata;
                    pready   <= pwrite || (RW == 2'd0);
                    pslverr  <= err_c && (pwrite || (RW == 2'd0));
                end
                ACCESS: begin
                    if (!psel) begin
                        state   <= IDLE;
                        pready  <= 1'b1;
                        pslverr <= 1'b0;
                    end else if (pready) begin
                        state   <= IDLE;
                        pslverr <= 1'b0;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                        if (rd_cnt <= 2'd1) begin
                            pready  <= 1'b1;
                            pslverr <= err_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_go   = (state == ACCESS) && pready && psel && penable && wr_q && !err_q;
    assign err_set = (state == ACCESS) && pready && pslverr;
    assign wm_w    = merge(32'(weight_reg[idx_q]), pwdata, pstrb);
    assign wm_s    = merge(32'(spike_threshold[idx_q]), pwdata, pstrb);
    assign wm_n    = merge(32'(neuron_threshold[nidx_q]), pwdata, pstrb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_reg       <= '0;
            spike_threshold  <= '0;
            neuron_threshold <= '0;
            layer_en         <= 1'b0;
            irq_en           <= 1'b0;
            start_pulse      <= 1'b0;
            done_st          <= 1'b0;
            err_st           <= 1'b0;
            spike_cnt        <= '0;
            irq              <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (wr_go) begin
                case (region_q)
                    R_W:  weight_reg[idx_q]        <= wm_w[WEIGHT_W-1:0];
                    R_ST: spike_threshold[idx_q]   <= wm_s[THRESH_W-1:0];
                    R_NT: neuron_threshold[nidx_q] <= wm_n[THRESH_W-1:0];
                    R_CTRL: if (pstrb[0]) begin
                        layer_en    <= pwdata[0];
                        irq_en      <= pwdata[2];
                        start_pulse <= pwdata[1];
                    end
                    default: ;
                endcase
            end
            // Set sources win over a simultaneous W1C.
            done_st <= layer_done | (done_st & ~(wr_go && region_q == R_STAT && pstrb[0] && pwdata[1]));
            err_st  <= err_set    | (err_st  & ~(wr_go && region_q == R_STAT && pstrb[0] && pwdata[2]));
            if (start_pulse)
                spike_cnt <= '0;
            else if (out_spike && spike_cnt != CNT_MAX)
                spike_cnt <= spike_cnt + 1'b1;
            irq <= irq_en & (done_st | err_st);
        end
    end
endmodule

// File: tb/tb_snn_csr_apb4.sv
// Directed bench for snn_csr_apb4: vector table for array/decode accesses plus
// hand-written sequences for start, counter, W1C, error and reset corners.
module tb_snn_csr_apb4;
    localparam int IN = 8, OUT = 4, NS = IN * OUT;

    logic clk = 1'b0, rst_n = 1'b0;
    logic psel = 0, penable = 0, pwrite = 0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic pready, pslverr;
    logic [NS-1:0][15:0]  weight_reg, spike_threshold;
    logic [OUT-1:0][15:0] neuron_threshold;
    logic layer_en, start_pulse, irq;
    logic layer_busy = 0, layer_done = 0, out_spike = 0;

    int compared = 0, mismatched = 0;

    snn_csr_apb4 #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .WEIGHT_W(16), .THRESH_W(16),
                   .CNT_W(8), .READ_WAIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .weight_reg(weight_reg), .spike_threshold(spike_threshold),
        .neuron_threshold(neuron_threshold), .layer_en(layer_en), .start_pulse(start_pulse),
        .layer_busy(layer_busy), .layer_done(layer_done), .out_spike(out_spike), .irq(irq));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic done_pulse,
                        output logic [31:0] rd, output logic er, output int waits);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1; waits = 0;
        while (!pready && waits < 8) begin
            @(posedge clk); #1; waits++;
        end
        if (!pready) chk("pready_timeout", {31'd0, pready}, 32'd1);
        rd = prdata; er = pslverr;
        if (done_pulse) layer_done = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0; layer_done = 0;
    endtask

    task automatic spikes(input int n);
        for (int k = 0; k < n; k++) begin
            out_spike = 1; @(posedge clk); #1;
            out_spike = 0; @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [15:0] addr; logic wr; logic [31:0] wd; logic [3:0] strb;
        logic [31:0] exp_rd; logic exp_err;
    } vec_t;
    vec_t tbl[16];

    logic [31:0] rd;
    logic er;
    int waits;

    initial begin
        tbl[0]  = '{16'h000C, 1, 32'hDEADBEEF, 4'b0011, 32'h0, 0};
        tbl[1]  = '{16'h000C, 0, 32'h0,        4'b0000, 32'h0000BEEF, 0};
        tbl[2]  = '{16'h1004, 1, 32'h12345678, 4'b1111, 32'h0, 0};
        tbl[3]  = '{16'h1004, 0, 32'h0,        4'b0000, 32'h00005678, 0};
        tbl[4]  = '{16'h2008, 1, 32'hAABBCCDD, 4'b0100, 32'h0, 0};
        tbl[5]  = '{16'h2008, 0, 32'h0,        4'b0000, 32'h0, 0};
        tbl[6]  = '{16'h200C, 1, 32'h0000A5C3, 4'b0010, 32'h0, 0};
        tbl[7]  = '{16'h200C, 0, 32'h0,        4'b0000, 32'h0000A500, 0};
        tbl[8]  = '{16'h007C, 1, 32'hFFFFFFFF, 4'b0000, 32'h0, 0};
        tbl[9]  = '{16'h007C, 0, 32'h0,        4'b0000, 32'h0, 0};
        tbl[10] = '{16'h4000, 0, 32'h0,        4'b0000, 32'h0, 1};
        tbl[11] = '{16'h0080, 0, 32'h0,        4'b0000, 32'h0, 1};
        tbl[12] = '{16'h2010, 0, 32'h0,        4'b0000, 32'h0, 1};
        tbl[13] = '{16'h300C, 0, 32'h0,        4'b0000, 32'h0, 1};
        tbl[14] = '{16'h107C, 1, 32'h0000FFFF, 4'b1111, 32'h0, 0};
        tbl[15] = '{16'h107C, 0, 32'h0,        4'b0000, 32'h0000FFFF, 0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_pready", {31'd0, pready}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_start", {31'd0, start_pulse}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);

        xfer(16'h3000, 0, 0, 0, 0, rd, er, waits);
        chk("ctrl_rst_waits", waits, 32'd1);
        chk("ctrl_rst_data", rd, 32'd0);
        chk("ctrl_rst_err", {31'd0, er}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            xfer(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].strb, 0, rd, er, waits);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_waits", i), waits, tbl[i].wr ? 32'd0 : 32'd1);
            if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        chk("weight_reg3", {16'd0, weight_reg[3]}, 32'h0000BEEF);
        chk("nthr3", {16'd0, neuron_threshold[3]}, 32'h0000A500);
        chk("nthr2", {16'd0, neuron_threshold[2]}, 32'h0);
        chk("sthr31", {16'd0, spike_threshold[31]}, 32'h0000FFFF);

        xfer(16'h3004, 1, 32'h4, 4'b0001, 0, rd, er, waits);
        xfer(16'h3004, 0, 0, 0, 0, rd, er, waits);
        chk("status_err_clr", rd, 32'h0);

        // CTRL write with START: exactly one start_pulse cycle
        xfer(16'h3000, 1, 32'h7, 4'b1111, 0, rd, er, waits);
        chk("layer_en", {31'd0, layer_en}, 32'd1);
        chk("start_hi", {31'd0, start_pulse}, 32'd1);
        @(posedge clk); #1;
        chk("start_lo", {31'd0, start_pulse}, 32'd0);
        xfer(16'h3000, 0, 0, 0, 0, rd, er, waits);
        chk("ctrl_read", rd, 32'h5);
        spikes(5);
        xfer(16'h3008, 0, 0, 0, 0, rd, er, waits);
        chk("cnt5", rd, 32'd5);
        // second START with a coincident spike: clear wins
        xfer(16'h3000, 1, 32'h7, 4'b0001, 0, rd, er, waits);
        out_spike = 1; @(posedge clk); #1; out_spike = 0;
        xfer(16'h3008, 0, 0, 0, 0, rd, er, waits);
        chk("cnt_start_clr", rd, 32'd0);

        layer_done = 1; @(posedge clk); #1; layer_done = 0;
        @(posedge clk); #1;
        chk("irq_done", {31'd0, irq}, 32'd1);
        xfer(16'h3004, 0, 0, 0, 0, rd, er, waits);
        chk("status_done", rd, 32'h2);
        xfer(16'h3004, 1, 32'h2, 4'b0001, 0, rd, er, waits);
        @(posedge clk); #1;
        chk("irq_clr", {31'd0, irq}, 32'd0);
        xfer(16'h3004, 0, 0, 0, 0, rd, er, waits);
        chk("status_w1c", rd, 32'h0);
        xfer(16'h3004, 1, 32'h2, 4'b0001, 1, rd, er, waits);
        xfer(16'h3004, 0, 0, 0, 0, rd, er, waits);
        chk("status_set_wins", rd, 32'h2);
        xfer(16'h3004, 1, 32'h3, 4'b0001, 0, rd, er, waits);
        chk("status_w1_busy_err", {31'd0, er}, 32'd0);

        spikes(3);
        xfer(16'h4000, 0, 0, 0, 0, rd, er, waits);
        chk("unmapped_err", {31'd0, er}, 32'd1);
        chk("unmapped_data", rd, 32'd0);
        xfer(16'h3008, 1, 32'h55, 4'b1111, 0, rd, er, waits);
        chk("cnt_wr_err", {31'd0, er}, 32'd1);
        xfer(16'h3008, 0, 0, 0, 0, rd, er, waits);
        chk("cnt_unchanged", rd, 32'd3);
        chk("cnt_rd_noerr", {31'd0, er}, 32'd0);
        layer_busy = 1;
        xfer(16'h3004, 0, 0, 0, 0, rd, er, waits);
        layer_busy = 0;
        chk("status_err_busy", rd, 32'h5);
        chk("irq_err", {31'd0, irq}, 32'd1);

        out_spike = 1;
        repeat (300) @(posedge clk);
        #1 out_spike = 0;
        xfer(16'h3008, 0, 0, 0, 0, rd, er, waits);
        chk("cnt_sat", rd, 32'hFF);

        // reset lands in the write access cycle, before the commit edge
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = 16'h0000; pwdata = 32'h1234; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1;
        #2 rst_n = 0;
        #2 psel = 0; penable = 0; pwrite = 0;
        chk("rst_mid_pready", {31'd0, pready}, 32'd1);
        @(posedge clk); #1 rst_n = 1;
        chk("rst_mid_w0", {16'd0, weight_reg[0]}, 32'h0);
        chk("rst_mid_en", {31'd0, layer_en}, 32'd0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        xfer(16'h0000, 0, 0, 0, 0, rd, er, waits);
        chk("rst_mid_rd", rd, 32'h0);
        xfer(16'h3008, 0, 0, 0, 0, rd, er, waits);
        chk("rst_mid_cnt", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/snn_csr_apb4.md
# snn_csr_apb4

Parametrised APB4 configuration/status block for one SNN neuron layer. It holds the synapse weight, spike-threshold and neuron-threshold arrays plus the layer control register. It adds byte strobes, error response, configurable read wait states, sticky W1C status, a self-clearing start pulse, a saturating output-spike counter and an interrupt. It sits between the system APB fabric and the layer datapath, one instance per layer.

## Interface
- INPUT_SIZE, 8, input neurons
- OUTPUT_SIZE, 4, output neurons
- WEIGHT_W, 16, stored weight width (1..32)
- THRESH_W, 16, stored spike/neuron threshold width (1..32)
- CNT_W, 16, spike counter width (1..32)
- READ_WAIT, 1, read access-phase wait states (0..3)
- WEIGHT_BASE_ADDR, 16'h0000; SPIKE_THRESH_BASE_ADDR, 16'h1000; NEURON_THRESH_BASE_ADDR, 16'h2000; CTRL_BASE_ADDR, 16'h3000
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- psel, penable, pwrite  in  1  APB control
- paddr  in  16  byte address; paddr[1:0] ignored
- pwdata  in  32  write data
- pstrb  in  4  byte write strobes
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid only with pready in access phase
- weight_reg  out  WEIGHT_W x INPUT_SIZE*OUTPUT_SIZE  weights, index i*OUTPUT_SIZE+j
- spike_threshold  out  THRESH_W x INPUT_SIZE*OUTPUT_SIZE  per-synapse thresholds
- neuron_threshold  out  THRESH_W x OUTPUT_SIZE  membrane thresholds
- layer_en  out  1  CTRL[0]
- start_pulse  out  1  one-cycle start strobe
- layer_busy  in  1  datapath busy level
- layer_done  in  1  datapath done pulse
- out_spike  in  1  one pulse per output spike
- irq  out  1  level interrupt

## Operation
- Map (word offsets from base): weights 0..N*4-4 (N=INPUT_SIZE*OUTPUT_SIZE); spike thresholds same; neuron thresholds 0..OUTPUT_SIZE*4-4; CTRL base+0, STATUS base+4, SPIKE_CNT base+8.
- CTRL RW: bit0 layer_en, bit2 irq_en. Bit1 START: writing 1 with pstrb[0] drives start_pulse high for exactly the cycle after the write commit. START always reads 0.
- STATUS: bit0 busy, RO and mirrors layer_busy. Bit1 done, sticky, set by layer_done. Bit2 err, sticky, set by any pslverr response. Bits 1 and 2 are W1C under pstrb[0]. Writes to bit0 are ignored without error.
- SPIKE_CNT RO: increments on out_spike and saturates at 2^CNT_W-1. It clears to 0 on start_pulse; if out_spike and start_pulse coincide, the result is 0.
- Set has priority over a W1C clear in the same cycle.
- irq = irq_en & (done | err), registered.
- Byte strobes apply per byte. Bits at or above the field width are dropped on write and read back as 0. pstrb=0 on a write commits nothing and gives no error.
- pslverr=1 on an unmapped address, or on a write to SPIKE_CNT. The access has no side effect; an errored read returns 0.

## Timing
- Reset values: all arrays 0, CTRL 0, STATUS sticky bits 0, SPIKE_CNT 0, prdata 0, pslverr 0, start_pulse 0, irq 0, pready 1.
- Setup phase (psel & !penable): the decode result and read data are registered at this edge, so prdata holds the value sampled at setup.
- Write access: pready=1 in the first access cycle (zero wait). The register updates at that edge.
- Read access: pready=0 for READ_WAIT cycles, then 1 for one cycle. A down-counter is loaded at setup and decrements during access.
- FSM: IDLE -> SETUP (psel & !penable) -> ACCESS (penable) -> IDLE when pready, or SETUP on a back-to-back transfer.
- pready is driven low only during read-access wait cycles.
- pslverr is asserted only in the cycle where pready=1.
- If rst_n asserts mid-transfer, the block returns to IDLE at once and no pending write is committed.

## Test plan
- Reset, then read CTRL base+0 with READ_WAIT=1: pready is low for 1 cycle, then prdata=0, pslverr=0.
- Write weight at offset 0x0C with 0xDEADBEEF and pstrb=4'b0011 (WEIGHT_W=16): weight_reg[3]=0xBEEF, and a read returns 0x0000BEEF.
- Write CTRL=0x7: layer_en=1, start_pulse high for exactly 1 cycle. Then apply 5 out_spike pulses: SPIKE_CNT reads 5. Write START again: SPIKE_CNT reads 0.
- Pulse layer_done with irq_en=1: STATUS[1]=1 and irq=1. Write STATUS=0x2: both clear. Then layer_done coincident with the W1C: STATUS[1] stays 1.
- Read address 0x4000, then write SPIKE_CNT: both give pslverr=1, read data 0, count unchanged, STATUS[2]=1.
- Drive 300 spikes with CNT_W=8: SPIKE_CNT saturates at 0xFF. Assert rst_n low mid-write: the target register stays 0.
